// File: rtl/ahb_decoder_dslv_pkg.sv
// Shared AHB types for the per-master address decoder and its default slave.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package AHB_package;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01
    } hresp_type;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } dslv_state_t;

    // Only NONSEQ and SEQ carry a real transfer; IDLE/BUSY never select or error.
    function automatic logic htrans_active(input htrans_type t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

endpackage

// File: rtl/ahb_decoder_dslv_default_slave.sv
// Default slave: two-cycle ERROR (wait, then ERROR with hready high) for unmapped transfers, plus a saturating error counter.
// Latency: response starts in the data phase, one hclk after the accepted address phase.
// Backpressure: inserts one wait state itself; only accepts a new address phase while hready is high.
module ahb_default_slave
    import AHB_package::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 hclk,
    input  logic                 hreset_n,
    input  logic                 hready,
    input  logic                 default_slv_sel,
    output logic                 dslv_hready,
    output hresp_type            dslv_hresp,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    dslv_state_t state;
    dslv_state_t state_nxt;
    logic        accept;

    // An unmapped transfer is accepted only when the bus completes its address phase.
    assign accept = hready & default_slv_sel;

    // State register; reset drops any in-flight ERROR sequence.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: ERR1 always proceeds to ERR2; ERR2 can chain straight into a new error.
    always_comb begin
        state_nxt = state;
        case (state)
            DS_IDLE: state_nxt = accept ? DS_ERR1 : DS_IDLE;
            DS_ERR1: state_nxt = DS_ERR2;
            DS_ERR2: state_nxt = accept ? DS_ERR1 : DS_IDLE;
            default: state_nxt = DS_IDLE;
        endcase
    end

    // Outputs: wait state in ERR1, ERROR held across both ERR cycles.
    always_comb begin
        dslv_hready = 1'b1;
        dslv_hresp  = OKAY;
        case (state)
            DS_ERR1: begin
                dslv_hready = 1'b0;
                dslv_hresp  = ERROR;
            end
            DS_ERR2: begin
                dslv_hready = 1'b1;
                dslv_hresp  = ERROR;
            end
            default: begin
                dslv_hready = 1'b1;
                dslv_hresp  = OKAY;
            end
        endcase
    end

    // Count each entry into ERR1, sticking at all-ones.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            err_cnt <= '0;
        end else if (accept && (state != DS_ERR1) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: rtl/ahb_decoder_dslv.sv
// Per-master AHB address decoder with integrated default slave; optional window remap under AHB_DEC_REMAP_EN.
// Latency: hreq/default_slv_sel combinational in the address phase; dphase_sel and default-slave response one hclk later.
// Backpressure: dphase_sel and the default slave only advance on hready=1; otherwise they hold.
module ahb_decoder_dslv
    import AHB_package::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int SLAVE_NUM      = 4,
    parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] LOW_ADDR  = '0,
    parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] HIGH_ADDR = '1,
    parameter int ERR_CNT_W      = 8
`ifdef AHB_DEC_REMAP_EN
    ,
    parameter int REMAP_IDX      = 1
`endif
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  htrans_type                htrans,
    input  logic                      hready,
`ifdef AHB_DEC_REMAP_EN
    input  logic                      hremap,
`endif
    output logic [SLAVE_NUM-1:0]      hreq,
    output logic                      default_slv_sel,
    output logic [SLAVE_NUM:0]        dphase_sel,
    output logic                      dslv_hready,
    output hresp_type                 dslv_hresp,
    output logic [ERR_CNT_W-1:0]      err_cnt
);

    logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] win_lo;
    logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] win_hi;
    logic [SLAVE_NUM-1:0]                     hit;
    logic [SLAVE_NUM-1:0]                     hit_prio;
    logic                                     active;

    assign active = htrans_active(htrans);

    // Effective address map; with remap active, slave 0 and REMAP_IDX trade windows.
    always_comb begin
        win_lo = LOW_ADDR;
        win_hi = HIGH_ADDR;
`ifdef AHB_DEC_REMAP_EN
        if (hremap) begin
            win_lo[0]         = LOW_ADDR[REMAP_IDX];
            win_hi[0]         = HIGH_ADDR[REMAP_IDX];
            win_lo[REMAP_IDX] = LOW_ADDR[0];
            win_hi[REMAP_IDX] = HIGH_ADDR[0];
        end
`endif
    end

    // Inclusive window compare per slave.
    always_comb begin
        hit = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            hit[i] = (haddr >= win_lo[i]) && (haddr <= win_hi[i]);
        end
    end

    // Overlapping windows resolve to the lowest index.
    always_comb begin
        logic found;
        found    = 1'b0;
        hit_prio = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (hit[i] && !found) begin
                hit_prio[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign hreq            = active ? hit_prio : '0;
    assign default_slv_sel = active & ~(|hit);

    // Data-phase select follows the accepted address phase; non-active transfers clear it.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            dphase_sel <= '0;
        end else if (hready) begin
            dphase_sel <= {default_slv_sel, hreq};
        end
    end

    ahb_default_slave #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_dslv (
        .hclk            (hclk),
        .hreset_n        (hreset_n),
        .hready          (hready),
        .default_slv_sel (default_slv_sel),
        .dslv_hready     (dslv_hready),
        .dslv_hresp      (dslv_hresp),
        .err_cnt         (err_cnt)
    );

endmodule

// File: tb/tb_ahb_decoder_dslv.sv
module tb_ahb_decoder_dslv;
    import AHB_package::*;

    localparam logic [1:0] OK = 2'd0;
    localparam logic [1:0] ER = 2'd1;

    logic        hclk;
    logic        hreset_n;
    logic [31:0] haddr;
    htrans_type  htrans;
    logic        hready;
`ifdef AHB_DEC_REMAP_EN
    logic        hremap;
    logic        remap_nxt;
`endif
    logic [1:0]  hreq;
    logic        default_slv_sel;
    logic [2:0]  dphase_sel;
    logic        dslv_hready;
    hresp_type   dslv_hresp;
    logic [1:0]  err_cnt;

    ahb_decoder_dslv #(
        .AHB_ADDR_WIDTH (32),
        .SLAVE_NUM      (2),
        .LOW_ADDR       ({32'h0000_1000, 32'h0000_0000}),
        .HIGH_ADDR      ({32'h0000_1FFF, 32'h0000_0FFF}),
        .ERR_CNT_W      (2)
    ) dut (
        .hclk            (hclk),
        .hreset_n        (hreset_n),
        .haddr           (haddr),
        .htrans          (htrans),
        .hready          (hready),
`ifdef AHB_DEC_REMAP_EN
        .hremap          (hremap),
`endif
        .hreq            (hreq),
        .default_slv_sel (default_slv_sel),
        .dphase_sel      (dphase_sel),
        .dslv_hready     (dslv_hready),
        .dslv_hresp      (dslv_hresp),
        .err_cnt         (err_cnt)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] hreq;
        logic       dss;
        logic [2:0] dph;
        logic       hr;
        logic [1:0] resp;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   row_id = 0;
    event chk_ev;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    // Monitor: every sample point that has a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge hclk or chk_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hreq",            int'(e.id), 32'(hreq),            32'(e.hreq));
                chk("default_slv_sel", int'(e.id), 32'(default_slv_sel), 32'(e.dss));
                chk("dphase_sel",      int'(e.id), 32'(dphase_sel),      32'(e.dph));
                chk("dslv_hready",     int'(e.id), 32'(dslv_hready),     32'(e.hr));
                chk("dslv_hresp",      int'(e.id), 32'(dslv_hresp),      32'(e.resp));
                chk("err_cnt",         int'(e.id), 32'(err_cnt),         32'(e.cnt));
            end
        end
    end

    // One directed vector: drive the address phase just after the edge, queue its expected outputs.
    task automatic r(input htrans_type tr, input logic [31:0] a, input logic rdy,
                     input logic [1:0] e_hreq, input logic e_dss, input logic [2:0] e_dph,
                     input logic e_hr, input logic [1:0] e_resp, input logic [1:0] e_cnt);
        exp_t e;
        @(posedge hclk);
        #1;
        htrans = tr;
        haddr  = a;
        hready = rdy;
`ifdef AHB_DEC_REMAP_EN
        hremap = remap_nxt;
`endif
        e.id   = 8'(row_id);
        e.hreq = e_hreq;
        e.dss  = e_dss;
        e.dph  = e_dph;
        e.hr   = e_hr;
        e.resp = e_resp;
        e.cnt  = e_cnt;
        exp_q.push_back(e);
        row_id++;
    endtask

    initial begin
        exp_t e;
        int   wait_cyc;
        hreset_n = 1'b0;
        htrans   = IDLE;
        haddr    = '0;
        hready   = 1'b1;
`ifdef AHB_DEC_REMAP_EN
        hremap    = 1'b0;
        remap_nxt = 1'b0;
`endif
        repeat (3) @(negedge hclk);
        hreset_n = 1'b1;

        //  tr      addr          rdy hreq  dss dph     hr  resp cnt
        r(IDLE,   32'h0000_0000, 1, 2'b00, 0, 3'b000, 1, OK, 2'd0); // 0 reset state
        r(NONSEQ, 32'h0000_0FFF, 1, 2'b01, 0, 3'b000, 1, OK, 2'd0); // 1 top of S0
        r(NONSEQ, 32'h0000_1000, 1, 2'b10, 0, 3'b001, 1, OK, 2'd0); // 2 base of S1
        r(NONSEQ, 32'h0000_1FFF, 1, 2'b10, 0, 3'b010, 1, OK, 2'd0); // 3 top of S1
        r(IDLE,   32'h0000_0000, 1, 2'b00, 0, 3'b010, 1, OK, 2'd0); // 4
        r(NONSEQ, 32'h0000_2000, 1, 2'b00, 1, 3'b000, 1, OK, 2'd0); // 5 unmapped
        r(IDLE,   32'h0000_0000, 0, 2'b00, 0, 3'b100, 0, ER, 2'd1); // 6 ERR1
        r(IDLE,   32'h0000_0000, 1, 2'b00, 0, 3'b100, 1, ER, 2'd1); // 7 ERR2
        r(IDLE,   32'h0000_0000, 1, 2'b00, 0, 3'b000, 1, OK, 2'd1); // 8 back to OKAY
        r(BUSY,   32'h0000_2000, 1, 2'b00, 0, 3'b000, 1, OK, 2'd1); // 9 BUSY never errors
        r(IDLE,   32'h0000_2000, 1, 2'b00, 0, 3'b000, 1, OK, 2'd1); // 10 IDLE never errors
        r(NONSEQ, 32'h0000_2000, 1, 2'b00, 1, 3'b000, 1, OK, 2'd1); // 11 b2b #1
        r(NONSEQ, 32'h0000_2000, 0, 2'b00, 1, 3'b100, 0, ER, 2'd2); // 12
        r(NONSEQ, 32'h0000_2000, 1, 2'b00, 1, 3'b100, 1, ER, 2'd2); // 13 b2b #2 in ERR2
        r(NONSEQ, 32'h0000_2000, 0, 2'b00, 1, 3'b100, 0, ER, 2'd3); // 14
        r(NONSEQ, 32'h0000_2000, 1, 2'b00, 1, 3'b100, 1, ER, 2'd3); // 15 b2b #3
        r(NONSEQ, 32'h0000_2000, 0, 2'b00, 1, 3'b100, 0, ER, 2'd3); // 16 saturated
        r(NONSEQ, 32'h0000_2000, 1, 2'b00, 1, 3'b100, 1, ER, 2'd3); // 17 b2b #4
        r(IDLE,   32'h0000_0000, 0, 2'b00, 0, 3'b100, 0, ER, 2'd3); // 18
        r(IDLE,   32'h0000_0000, 1, 2'b00, 0, 3'b100, 1, ER, 2'd3); // 19
        r(IDLE,   32'h0000_0000, 1, 2'b00, 0, 3'b000, 1, OK, 2'd3); // 20
        r(SEQ,    32'h0000_1800, 1, 2'b10, 0, 3'b000, 1, OK, 2'd3); // 21 SEQ decodes
        r(NONSEQ, 32'h0000_0010, 0, 2'b01, 0, 3'b010, 1, OK, 2'd3); // 22 hready low
        r(NONSEQ, 32'h0000_0010, 1, 2'b01, 0, 3'b010, 1, OK, 2'd3); // 23 select held
        r(IDLE,   32'h0000_0000, 1, 2'b00, 0, 3'b001, 1, OK, 2'd3); // 24
        r(NONSEQ, 32'h0000_3000, 1, 2'b00, 1, 3'b000, 1, OK, 2'd3); // 25 unmapped
        r(IDLE,   32'h0000_0000, 0, 2'b00, 0, 3'b100, 0, ER, 2'd3); // 26 ERR1

        // Asynchronous reset while the default slave sits in ERR1.
        @(negedge hclk);
        #2;
        hreset_n = 1'b0;
        e.id   = 8'(row_id);
        e.hreq = 2'b00;
        e.dss  = 1'b0;
        e.dph  = 3'b000;
        e.hr   = 1'b1;
        e.resp = OK;
        e.cnt  = 2'd0;
        exp_q.push_back(e);
        row_id++;
        #1;
        ->chk_ev;
        repeat (2) @(negedge hclk);
        hreset_n = 1'b1;

        r(NONSEQ, 32'h0000_0FFF, 1, 2'b01, 0, 3'b000, 1, OK, 2'd0); // post-reset
        r(NONSEQ, 32'h0000_1FFF, 1, 2'b10, 0, 3'b001, 1, OK, 2'd0);
`ifdef AHB_DEC_REMAP_EN
        remap_nxt = 1'b1;
        r(NONSEQ, 32'h0000_0004, 1, 2'b10, 0, 3'b010, 1, OK, 2'd0); // S0 window now S1
        r(NONSEQ, 32'h0000_1004, 1, 2'b01, 0, 3'b010, 1, OK, 2'd0); // S1 window now S0
        remap_nxt = 1'b0;
        r(IDLE,   32'h0000_0000, 1, 2'b00, 0, 3'b001, 1, OK, 2'd0);
`else
        r(IDLE,   32'h0000_0000, 1, 2'b00, 0, 3'b010, 1, OK, 2'd0);
`endif

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge hclk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
